// File: rtl/anubis_omega_extract.sv
// anubis_omega_extract: iterative ANUBIS omega step.
// Reduces an N-row key state (N = 4..NMAX rows of 4 bytes) to a 4x4 byte matrix
// out = V . kappa over GF(2^8) with poly 0x11D, where V[i][k] = c_i^k and
// c = {01,02,04,08}. Horner evaluation consumes one key row per cycle, highest row first.
module anubis_omega_extract #(
  parameter int NMAX = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           nrows,
  input  logic [32*NMAX-1:0]   kstate,
  output logic                 busy,
  output logic                 err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         odat
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0] NMAX_C = 4'(NMAX);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [32*NMAX-1:0]  r_kstate;
  logic [127:0]        r_acc;
  logic [127:0]        r_odat;
  logic [3:0]          r_cnt;
  logic                r_err;

  logic                w_nrows_ok;
  logic                w_accept;
  logic                w_reject;
  logic                w_last;
  logic                w_hs;
  logic [31:0]         w_row;
  logic [127:0]        w_acc_nxt;

  // GF(2^8) multiply by x, reduction polynomial 0x11D
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1D : 8'h00);
  endfunction

  // Multiply by c_lane = 2^lane (lane 0..3) as repeated xtime
  function automatic logic [7:0] xmul(input logic [7:0] b, input int lane);
    logic [7:0] v;
    v = b;
    for (int n = 0; n < 3; n++) begin
      if (n < lane) v = xtime(v);
    end
    return v;
  endfunction

  assign w_nrows_ok = (nrows >= 4'd4) && (nrows <= NMAX_C);
  assign w_accept   = (r_state == S_IDLE) && start && w_nrows_ok;
  assign w_reject   = (r_state == S_IDLE) && start && !w_nrows_ok;
  assign w_last     = (r_state == S_RUN) && (r_cnt == 4'd0);
  assign w_hs       = (r_state == S_DONE) && out_ready;
  assign w_row      = r_kstate[32*int'(r_cnt) +: 32];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> RUN -> DONE -> IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)   w_state_nxt = S_DONE;
      S_DONE:  if (w_hs)     w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state only, so no input reaches an output combinationally
  always_comb begin
    busy      = (r_state != S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // One Horner step for all 4 lanes: acc[i][j] = acc[i][j]*c_i ^ kappa[cnt][j]
  always_comb begin
    w_acc_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        w_acc_nxt[8*(4*i+j) +: 8] = xmul(r_acc[8*(4*i+j) +: 8], i) ^ w_row[8*j +: 8];
      end
    end
  end

  // Illegal row count on a start request gives a single-cycle error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_reject;
  end

  // Datapath: capture key on accept, iterate rows in RUN, publish result on last row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kstate <= '0;
      r_acc    <= '0;
      r_odat   <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_kstate <= kstate;
      r_acc    <= '0;
      r_cnt    <= nrows - 4'd1;
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_nxt;
      if (w_last) r_odat <= w_acc_nxt;
      else        r_cnt  <= r_cnt - 4'd1;
    end
  end

  assign err  = r_err;
  assign odat = r_odat;

endmodule

// File: tb/tb_anubis_omega_extract.sv
// Directed bench for anubis_omega_extract: fixed vectors with hand-derived results,
// plus an independent power-sum GF(2^8) model for the all-ones 10-row case.
module tb_anubis_omega_extract;

  logic         clk;
  logic         rst;
  logic         start;
  logic [3:0]   nrows;
  logic [319:0] kstate;
  logic         busy;
  logic         err;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] odat;

  int checks;
  int failures;

  anubis_omega_extract #(.NMAX(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .nrows     (nrows),
    .kstate    (kstate),
    .busy      (busy),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .odat      (odat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // General GF(2^8) shift-and-add multiply, poly 0x11D
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int n = 0; n < 8; n++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] gpow(input logic [7:0] c, input int k);
    logic [7:0] r;
    r = 8'h01;
    for (int n = 0; n < k; n++) r = gmul(r, c);
    return r;
  endfunction

  // out[i][j] = XOR_k c_i^k * kappa[k][j]
  function automatic logic [127:0] omega_model(input logic [319:0] ks, input int n);
    logic [127:0] o;
    logic [7:0]   s;
    logic [7:0]   c;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      c = 8'h01 << i;
      for (int j = 0; j < 4; j++) begin
        s = 8'h00;
        for (int k = 0; k < n; k++) s = s ^ gmul(gpow(c, k), ks[32*k+8*j +: 8]);
        o[8*(4*i+j) +: 8] = s;
      end
    end
    return o;
  endfunction

  // Issue one start; optionally scramble inputs after capture; return edges to out_valid
  task automatic start_job(input logic [3:0] n, input logic [319:0] ks,
                           input bit scramble, output int lat);
    @(negedge clk);
    start = 1'b1; nrows = n; kstate = ks;
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      kstate = '1;
      nrows  = 4'd2;
    end
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; nrows = 4'd0; kstate = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (odat !== 128'h0) begin failures++; $display("FAIL reset_odat got=%h exp=0", odat); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_row0();
    int lat;
    logic [319:0] ks;
    ks = '0; ks[31:0] = 32'h04030201;
    start_job(4'd4, ks, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL row0_latency got=%0d exp=4", lat); end
    checks++; if (odat !== 128'h04030201_04030201_04030201_04030201) begin
      failures++; $display("FAIL row0_odat got=%h exp=%h", odat, 128'h04030201_04030201_04030201_04030201); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL row0_busy_done got=%b exp=1", busy); end
    release_out();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL row0_valid_drop got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL row0_idle_busy got=%b exp=0", busy); end
    checks++; if (odat !== 128'h04030201_04030201_04030201_04030201) begin
      failures++; $display("FAIL row0_odat_hold got=%h", odat); end
  endtask

  task automatic test_row1();
    int lat;
    logic [319:0] ks;
    ks = '0; ks[32] = 1'b1;
    start_job(4'd4, ks, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL row1_latency got=%0d exp=4", lat); end
    checks++; if (odat !== 128'h00000008_00000004_00000002_00000001) begin
      failures++; $display("FAIL row1_odat got=%h exp=%h", odat, 128'h00000008_00000004_00000002_00000001); end
    release_out();
  endtask

  task automatic test_row3_scrambled();
    int lat;
    logic [319:0] ks;
    ks = '0; ks[96] = 1'b1;
    start_job(4'd4, ks, 1'b1, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL row3_latency got=%0d exp=4", lat); end
    checks++; if (odat !== 128'h0000003A_00000040_00000008_00000001) begin
      failures++; $display("FAIL row3_odat got=%h exp=%h", odat, 128'h0000003A_00000040_00000008_00000001); end
    release_out();
  endtask

  task automatic test_n10_ones();
    int lat;
    logic [319:0] ks;
    logic [127:0] exp;
    ks  = '1;
    exp = omega_model(ks, 10);
    start_job(4'd10, ks, 1'b0, lat);
    checks++; if (lat !== 10) begin failures++; $display("FAIL n10_latency got=%0d exp=10", lat); end
    checks++; if (odat[31:0] !== 32'h0) begin failures++; $display("FAIL n10_row0 got=%h exp=0", odat[31:0]); end
    checks++; if (odat !== exp) begin failures++; $display("FAIL n10_odat got=%h exp=%h", odat, exp); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [319:0] ks;
    logic [319:0] ks2;
    ks = '0; ks[64] = 1'b1;
    start_job(4'd4, ks, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL stall_latency got=%0d exp=4", lat); end
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin start = 1'b1; nrows = 4'd4; kstate = '1; end
      else if (c == 9) begin start = 1'b1; nrows = 4'd3; end
      else start = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid c=%0d got=%b exp=1", c, out_valid); end
      checks++; if (odat !== 128'h00000040_00000010_00000004_00000001) begin
        failures++; $display("FAIL stall_odat c=%0d got=%h", c, odat); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL stall_err c=%0d got=%b exp=0", c, err); end
    end
    start = 1'b0;
    release_out();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    // restart in the very first idle cycle
    ks2 = '0; ks2[31:0] = 32'h04030201;
    start = 1'b1; nrows = 4'd4; kstate = ks2;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    lat = 0;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    checks++; if (lat !== 4) begin failures++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
    checks++; if (odat !== 128'h04030201_04030201_04030201_04030201) begin
      failures++; $display("FAIL b2b_odat got=%h", odat); end
    release_out();
  endtask

  task automatic test_err();
    logic [3:0] bad [2];
    bad[0] = 4'd3; bad[1] = 4'd11;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      start = 1'b1; nrows = bad[b]; kstate = '1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_pulse n=%0d got=%b exp=1", bad[b], err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL err_busy n=%0d got=%b exp=0", bad[b], busy); end
      @(negedge clk);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear n=%0d got=%b exp=0", bad[b], err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL err_stay_idle n=%0d got=%b exp=0", bad[b], busy); end
    end
  endtask

  task automatic test_abort();
    int lat;
    bit seen;
    logic [319:0] ks;
    @(negedge clk);
    start = 1'b1; nrows = 4'd8; kstate = '1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", out_valid); end
    checks++; if (odat !== 128'h0) begin failures++; $display("FAIL abort_odat got=%h exp=0", odat); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL abort_err got=%b exp=0", err); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_result got=%b exp=0", seen); end
    ks = '0; ks[32] = 1'b1;
    start_job(4'd4, ks, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL post_abort_latency got=%0d exp=4", lat); end
    checks++; if (odat !== 128'h00000008_00000004_00000002_00000001) begin
      failures++; $display("FAIL post_abort_odat got=%h", odat); end
    release_out();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_row0();
    test_row1();
    test_row3_scrambled();
    test_n10_ones();
    test_back_to_back();
    test_err();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
